// File: rtl/dijkstra_ci_initiator.sv
// Custom-instruction initiator: accepts one command, drives a CI responder and returns its result.
// Optional WAIT timeout is compiled in with the macro DIJKSTRA_CI_TIMEOUT_EN.
module dijkstra_ci_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_n,
    input  logic [31:0] cmd_dataa,
    input  logic [31:0] cmd_datab,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic        ci_start,
    output logic        ci_clock_enable,
    output logic [7:0]  ci_n,
    output logic [31:0] ci_dataa,
    output logic [31:0] ci_datab,
    input  logic [31:0] ci_result,
    input  logic        ci_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES >= (64'd1 << CNT_WIDTH)) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES does not fit in CNT_WIDTH bits");
    end

    state_t      state_q, state_d;
    logic [7:0]  n_q, n_d;
    logic [31:0] dataa_q, dataa_d;
    logic [31:0] datab_q, datab_d;
    logic [31:0] result_q, result_d;

`ifdef DIJKSTRA_CI_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    // State and datapath registers; reset wins over every input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            n_q       <= 8'd0;
            dataa_q   <= 32'd0;
            datab_q   <= 32'd0;
            result_q  <= 32'd0;
`ifdef DIJKSTRA_CI_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            dataa_q   <= dataa_d;
            datab_q   <= datab_d;
            result_q  <= result_d;
`ifdef DIJKSTRA_CI_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state logic; operands are only latched on an accepted command.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        dataa_d   = dataa_q;
        datab_d   = datab_q;
        result_d  = result_q;
`ifdef DIJKSTRA_CI_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    n_d     = cmd_n;
                    dataa_d = cmd_dataa;
                    datab_d = cmd_datab;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
`ifdef DIJKSTRA_CI_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A ready arriving on the limit cycle still counts as a normal completion.
                if (ci_ready) begin
                    result_d  = ci_result;
`ifdef DIJKSTRA_CI_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d   = S_RESP;
`ifdef DIJKSTRA_CI_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d     = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    result_d  = 32'hFFFF_FFFF;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d     = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    state_d   = S_WAIT;
                end
`else
                end else begin
                    state_d   = S_WAIT;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready       = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign ci_start        = (state_q == S_ISSUE);
    assign ci_clock_enable = (state_q == S_WAIT);
    assign rsp_valid       = (state_q == S_RESP);
    assign ci_n            = n_q;
    assign ci_dataa        = dataa_q;
    assign ci_datab        = datab_q;
    assign rsp_result      = result_q;
`ifdef DIJKSTRA_CI_TIMEOUT_EN
    assign rsp_timeout     = timeout_q;
`else
    assign rsp_timeout     = 1'b0;
`endif

endmodule
